// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerator arbiter: lane geometry,
// result width and the sequencer state encoding.
package accel_pkg;

  localparam int NUM_LANES = 8;
  localparam int DATA_W    = 32;
  localparam int RESULT_W  = 64;
  localparam int VEC_W     = NUM_LANES * DATA_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } arb_state_t;

  // Increment an index modulo n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 32'sd1) ? 32'sd0 : idx + 32'sd1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr_i,
// wrapping modulo N_REQ.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    found   = 1'b0;
    cand    = '0;
    grant_o = '0;
    idx_o   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = IDX_W'((int'(ptr_i) + off) % N_REQ);
      if (!found && req_valid_i[cand]) begin
        found          = 1'b1;
        idx_o          = cand;
        grant_o[cand]  = 1'b1;
      end else begin
        found = found;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/accel_arbiter.sv
// Round-robin arbiter/sequencer in front of one shared dot-product accelerator.
// Optional WAIT timeout with accelerator kick: define ACCEL_ARB_TIMEOUT_EN.
module accel_arbiter
  import accel_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [N_REQ*VEC_W-1:0]    req_a_i,
  input  logic [N_REQ*VEC_W-1:0]    req_b_i,
  output logic [N_REQ-1:0]          rsp_valid_o,
  output logic [RESULT_W-1:0]       rsp_result_o,
  output logic                      rsp_error_o,
  output logic                      busy_o,
  output logic                      acc_start_o,
  output logic                      acc_rst_o,
  output logic [VEC_W-1:0]          acc_a_o,
  output logic [VEC_W-1:0]          acc_b_o,
  input  logic                      acc_done_i,
  input  logic [RESULT_W-1:0]       acc_result_i
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("accel_arbiter: unsupported N_REQ or TIMEOUT_CYCLES");
  end

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [VEC_W-1:0]     acc_a_q, acc_a_d;
  logic [VEC_W-1:0]     acc_b_q, acc_b_d;
  logic                 seen_low_q, seen_low_d;
  logic [RESULT_W-1:0]  result_q, result_d;
  logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic                 acc_start_q;
  logic                 busy_q;

  logic [N_REQ-1:0]     pick_grant_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic                 pick_any_s;
  logic                 done_evt_s;

`ifdef ACCEL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 error_q, error_d;
  logic                 kick_q;
  logic                 timeout_s;
`endif

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_valid_i (req_valid_i),
    .ptr_i       (ptr_q),
    .grant_o     (pick_grant_s),
    .idx_o       (pick_idx_s),
    .any_o       (pick_any_s)
  );

  // A done counts only after done has been seen low in this WAIT, so a level
  // left high by the previous operation cannot complete the new one.
  assign done_evt_s = acc_done_i && seen_low_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    seen_low_d  = seen_low_q;
    result_d    = result_q;
    rsp_valid_d = '0;
`ifdef ACCEL_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    error_d     = error_q;
    timeout_s   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d = START;
          gidx_d  = pick_idx_s;
          acc_a_d = VEC_W'(req_a_i >> (int'(pick_idx_s) * VEC_W));
          acc_b_d = VEC_W'(req_b_i >> (int'(pick_idx_s) * VEC_W));
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        seen_low_d = 1'b0;
`ifdef ACCEL_ARB_TIMEOUT_EN
        cnt_d      = '0;
`endif
        state_d    = WAIT;
      end
      WAIT: begin
        seen_low_d = seen_low_q | ~acc_done_i;
        if (done_evt_s) begin
          state_d = CAPTURE;
        end else begin
`ifdef ACCEL_ARB_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            timeout_s = 1'b1;
            result_d  = '0;
            error_d   = 1'b1;
            state_d   = RESP;
          end else begin
            state_d   = WAIT;
          end
`else
          state_d = WAIT;
`endif
        end
      end
      CAPTURE: begin
        result_d = acc_result_i;
`ifdef ACCEL_ARB_TIMEOUT_EN
        error_d  = 1'b0;
`endif
        state_d  = RESP;
      end
      RESP: begin
        ptr_d   = IDX_W'(wrap_inc(int'(gidx_q), N_REQ));
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d == RESP) begin
      rsp_valid_d[gidx_d] = 1'b1;
    end else begin
      rsp_valid_d = '0;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      seen_low_q  <= 1'b0;
      result_q    <= '0;
      rsp_valid_q <= '0;
      acc_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      seen_low_q  <= seen_low_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
      acc_start_q <= (state_d == START);
      busy_q      <= (state_d != IDLE);
    end
  end

`ifdef ACCEL_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
      kick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      error_q <= error_d;
      kick_q  <= timeout_s;
    end
  end

  assign rsp_error_o = error_q;
  assign acc_rst_o   = rst_i | kick_q;
`else
  assign rsp_error_o = 1'b0;
  assign acc_rst_o   = rst_i;
`endif

  assign req_ready_o  = (state_q == IDLE) ? pick_grant_s : '0;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = result_q;
  assign busy_o       = busy_q;
  assign acc_start_o  = acc_start_q;
  assign acc_a_o      = acc_a_q;
  assign acc_b_o      = acc_b_q;

endmodule

// File: tb/tb_accel_arbiter.sv
// Bench for accel_arbiter: behavioural accelerator stub, cycle model of the
// arbitration/latency rules, and directed scenarios with literal results.
module tb_accel_arbiter;

  localparam int N = 4;
`ifdef ACCEL_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*256-1:0] req_a = '0;
  logic [N*256-1:0] req_b = '0;
  logic [N-1:0]     rsp_valid;
  logic [63:0]      rsp_result;
  logic             rsp_error;
  logic             busy;
  logic             acc_start;
  logic             acc_rst;
  logic [255:0]     acc_a;
  logic [255:0]     acc_b;
  logic             acc_done;
  logic [63:0]      acc_result;

  always #5 clk = ~clk;

  accel_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .rsp_valid_o  (rsp_valid),
    .rsp_result_o (rsp_result),
    .rsp_error_o  (rsp_error),
    .busy_o       (busy),
    .acc_start_o  (acc_start),
    .acc_rst_o    (acc_rst),
    .acc_a_o      (acc_a),
    .acc_b_o      (acc_b),
    .acc_done_i   (acc_done),
    .acc_result_i (acc_result)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] pack(input int v0, input int v1, input int v2, input int v3,
                                        input int v4, input int v5, input int v6, input int v7);
    return {32'(v7), 32'(v6), 32'(v5), 32'(v4), 32'(v3), 32'(v2), 32'(v1), 32'(v0)};
  endfunction

  function automatic logic [63:0] dot(input logic [255:0] a, input logic [255:0] b);
    longint s;
    logic [31:0] x, y;
    s = 0;
    for (int k = 0; k < 8; k++) begin
      x = 32'(a >> (32 * k));
      y = 32'(b >> (32 * k));
      s += longint'($signed(x)) * longint'($signed(y));
    end
    return 64'(s);
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    return N'(1'b1) << i;
  endfunction

  function automatic int rr_win(input logic [N-1:0] v, input int p);
    int i;
    for (int o = 0; o < N; o++) begin
      i = (p + o) % N;
      if (((v >> i) & N'(1'b1)) != '0) return i;
    end
    return -1;
  endfunction

  // Accelerator stub: result from the latched operands, done after stub_lat
  // cycles and held until the next start; stale mode keeps the old done one
  // cycle into WAIT, hold mode forces done high permanently.
  int          stub_lat   = 3;
  bit          stub_stale = 1'b0;
  bit          stub_hold  = 1'b0;
  logic        st_done    = 1'b0;
  int          st_cnt     = 0;
  logic [63:0] st_res     = '0;

  always @(posedge clk) begin
    if (acc_rst) begin
      st_cnt  <= 0;
      st_done <= 1'b0;
    end else if (acc_start) begin
      st_cnt  <= stub_lat;
      st_done <= stub_stale ? st_done : 1'b0;
      st_res  <= dot(acc_a, acc_b);
    end else if (st_cnt > 0) begin
      st_cnt <= st_cnt - 1;
      if (st_cnt == 1) st_done <= 1'b1;
      else if (st_cnt == stub_lat) st_done <= 1'b0;
    end
  end

  assign acc_done   = stub_hold | st_done;
  assign acc_result = st_res;

  // Reference model: one transaction at a time, timeline relative to accept.
  bit           check_en = 1'b0;
  bit           m_idle   = 1'b1;
  int           m_ptr    = 0;
  int           m_g      = 0;
  int           m_t      = -10;
  int           m_resp   = -1;
  int           m_wdone  = -1;
  bit           m_seen   = 1'b0;
  bit           m_to     = 1'b0;
  logic [63:0]  m_res    = '0;
  logic         m_err    = 1'b0;
  logic [255:0] m_a      = '0;
  logic [255:0] m_b      = '0;

  initial begin : model
    int c;
    int w;
    logic [N-1:0] e_ready, e_rspv;
    logic e_rst;
    c = 0;
    forever begin
      @(negedge clk);
      if (check_en) begin
        w       = rr_win(req_valid, m_ptr);
        e_ready = (m_idle && w >= 0) ? oh(w) : '0;
        e_rspv  = (!m_idle && c == m_resp) ? oh(m_g) : '0;
        e_rst   = rst | (m_to && !m_idle && c == m_resp);
        chk("req_ready", 256'(req_ready), 256'(e_ready));
        chk("busy", 256'(busy), 256'(!m_idle));
        chk("acc_start", 256'(acc_start), 256'(!m_idle && c == m_t + 1));
        chk("rsp_valid", 256'(rsp_valid), 256'(e_rspv));
        chk("rsp_result", 256'(rsp_result), 256'(m_res));
        chk("rsp_error", 256'(rsp_error), 256'(m_err));
        chk("acc_a", acc_a, m_a);
        chk("acc_b", acc_b, m_b);
        chk("acc_rst", 256'(acc_rst), 256'(e_rst));
        if (rst) begin
          m_idle = 1'b1; m_ptr = 0; m_a = '0; m_b = '0; m_res = '0; m_err = 1'b0;
          m_resp = -1; m_wdone = -1; m_to = 1'b0;
        end else if (m_idle) begin
          if (w >= 0) begin
            m_idle = 1'b0; m_t = c; m_g = w;
            m_a = 256'(req_a >> (256 * w));
            m_b = 256'(req_b >> (256 * w));
            m_seen = 1'b0; m_resp = -1; m_wdone = -1; m_to = 1'b0;
          end
        end else if (c == m_resp) begin
          m_idle = 1'b1;
          m_ptr  = (m_g + 1) % N;
        end else if (m_wdone >= 0) begin
          if (c == m_wdone + 1) begin
            m_res = acc_result;
            m_err = 1'b0;
          end
        end else if (c >= m_t + 2) begin
          if (acc_done && m_seen) begin
            m_wdone = c;
            m_resp  = c + 2;
          end else begin
            if (!acc_done) m_seen = 1'b1;
`ifdef ACCEL_ARB_TIMEOUT_EN
            if (c - (m_t + 1) == TO) begin
              m_resp = c + 1; m_res = '0; m_err = 1'b1; m_to = 1'b1;
            end
`endif
          end
        end
      end
      c++;
    end
  end

  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic set_req(input int i, input logic [255:0] a, input logic [255:0] b);
    logic [N*256-1:0] m, ta, tb;
    m  = {{((N-1)*256){1'b0}}, {256{1'b1}}} << (256 * i);
    ta = {{((N-1)*256){1'b0}}, a} << (256 * i);
    tb = {{((N-1)*256){1'b0}}, b} << (256 * i);
    req_a = (req_a & ~m) | ta;
    req_b = (req_b & ~m) | tb;
  endtask

  task automatic wait_rsp(input string nm, input int idx, input logic [63:0] er, input logic ee);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      tick();
      if (rsp_valid !== '0) got = 1'b1;
    end
    chk({nm, "_seen"}, 256'(got), 256'(1'b1));
    chk({nm, "_who"}, 256'(rsp_valid), 256'(oh(idx)));
    chk({nm, "_result"}, 256'(rsp_result), 256'(er));
    chk({nm, "_error"}, 256'(rsp_error), 256'(ee));
  endtask

  initial begin : stim
    int nrsp;
    logic [63:0] neg266;
    neg266 = -64'sd266;

    rst = 1'b1;
    tick();
    check_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_busy", 256'(busy), 256'(1'b0));
    chk("reset_rsp_valid", 256'(rsp_valid), 256'(1'b0));
    chk("reset_acc_start", 256'(acc_start), 256'(1'b0));
    chk("reset_rsp_result", 256'(rsp_result), 256'(1'b0));

    // Single requester, known dot product.
    stub_lat = 3;
    set_req(0, pack(1, 2, 3, 4, 5, 6, 7, 8), pack(10, 10, 10, 10, 1, 1, 1, 1));
    req_valid = 4'b0001;
    wait_rsp("t1", 0, 64'd126, 1'b0);

    // All four valid after reset: served 0,1,2,3.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    stub_lat = 2;
    for (int i = 0; i < N; i++) set_req(i, pack(i+1, i+1, i+1, i+1, i+1, i+1, i+1, i+1),
                                         pack(1, 1, 1, 1, 1, 1, 1, 1));
    req_valid = 4'b1111;
    wait_rsp("t2_r0", 0, 64'd8, 1'b0);
    wait_rsp("t2_r1", 1, 64'd16, 1'b0);
    wait_rsp("t2_r2", 2, 64'd24, 1'b0);
    wait_rsp("t2_r3", 3, 64'd32, 1'b0);

    // Fairness: after requester 1, requesters 0 and 2 together -> 2 then 0.
    stub_lat = 5;
    req_valid = 4'b0010;
    wait_rsp("t3_r1", 1, 64'd16, 1'b0);
    req_valid = 4'b0101;
    wait_rsp("t3_first", 2, 64'd24, 1'b0);
    wait_rsp("t3_second", 0, 64'd8, 1'b0);

    // Signed lanes, with a done level left over from the previous operation.
    stub_lat   = 4;
    stub_stale = 1'b1;
    set_req(3, pack(10, -5, 100, -1, 0, 20, -2, 1), pack(2, 10, -1, 20, 50, -5, 4, -8));
    req_valid = 4'b1000;
    wait_rsp("t4", 3, neg266, 1'b0);
    stub_stale = 1'b0;

    // Reset while waiting on the accelerator.
    stub_lat = 10;
    set_req(1, pack(5, 5, 5, 5, 5, 5, 5, 5), pack(1, 1, 1, 1, 1, 1, 1, 1));
    req_valid = 4'b0010;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_busy_before", 256'(busy), 256'(1'b1));
    rst = 1'b1;
    #1;
    chk("t5_acc_rst", 256'(acc_rst), 256'(1'b1));
    tick();
    rst = 1'b0;
    chk("t5_busy_after", 256'(busy), 256'(1'b0));
    chk("t5_acc_a_after", acc_a, 256'(1'b0));
    nrsp = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rsp_valid !== '0) nrsp++;
    end
    chk("t5_no_rsp", 256'(nrsp), 256'(1'b0));
    stub_lat = 3;
    set_req(2, pack(3, 3, 3, 3, 3, 3, 3, 3), pack(1, 1, 1, 1, 1, 1, 1, 1));
    req_valid = 4'b0100;
    wait_rsp("t5_r2", 2, 64'd24, 1'b0);

`ifdef ACCEL_ARB_TIMEOUT_EN
    // Done stuck high: never seen low, so the WAIT limit fires.
    stub_hold = 1'b1;
    set_req(0, pack(1, 1, 1, 1, 1, 1, 1, 1), pack(1, 1, 1, 1, 1, 1, 1, 1));
    req_valid = 4'b0001;
    wait_rsp("t6", 0, 64'd0, 1'b1);
    chk("t6_acc_rst_hi", 256'(acc_rst), 256'(1'b1));
    tick();
    chk("t6_acc_rst_lo", 256'(acc_rst), 256'(1'b0));
    stub_hold = 1'b0;
`endif

    for (int i = 0; i < 4; i++) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
